// File: rtl/mul_pkg.sv
// Shared types and decode helpers for the RV32M multiply sequencer.
package mul_pkg;

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE} mul_state_t;

  localparam logic [2:0] MULSEL_NONE   = 3'b000;
  localparam logic [2:0] MULSEL_MUL    = 3'b001;
  localparam logic [2:0] MULSEL_MULH   = 3'b010;
  localparam logic [2:0] MULSEL_MULHSU = 3'b011;
  localparam logic [2:0] MULSEL_MULHU  = 3'b100;

  function automatic logic is_mul_op(input logic [2:0] mulsel);
    return (mulsel >= MULSEL_MUL) && (mulsel <= MULSEL_MULHU);
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned iterative shift-add multiplier datapath: BITS_PER_CYCLE multiplier
// bits retired per step, magnitude product optionally negated on output.
module mul_shift_add_core #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                negate,
  input  logic [XLEN-1:0]     mcand,
  input  logic [XLEN-1:0]     mplier,
  output logic                last,
  output logic [2*XLEN-1:0]   product
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int NITER = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (NITER > 1) ? $clog2(NITER) : 1;

  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN+B-1:0] pp;
  logic [XLEN+B-1:0] sum;

  // Upper half holds the running sum, lower half the unconsumed multiplier
  // bits; the extra B bits of sum absorb the carry before the right shift.
  always_comb begin
    pp  = {{B{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc[B-1:0]};
    sum = {{B{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (load) begin
      mcand_q <= mcand;
      acc     <= {{XLEN{1'b0}}, mplier};
      cnt     <= '0;
    end else if (step) begin
      acc <= {sum, acc[XLEN-1:B]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last    = (cnt == CNT_W'(NITER - 1));
  assign product = negate ? -acc : acc;

endmodule

// File: rtl/mul_controller.sv
// RV32M multiply sequencer in EX: stalls the pipe while the shift-add core runs.
// Optional MUL_ZERO_SKIP_EN: zero operand completes in one cycle with result 0.
module mul_controller
  import mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            start,
  input  logic [2:0]      mulsel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  mul_state_t        state, next_state;
  logic              accept;
  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              low_q, neg_q;
  logic [4:0]        rd_q;
  logic              last;
  logic [2*XLEN-1:0] product;
`ifdef MUL_ZERO_SKIP_EN
  logic              zero_op;
  assign zero_op = (rs1_data == '0) || (rs2_data == '0);
`endif

  // rs1 is signed except for mulhu; rs2 only for mul/mulh (mul's low half is
  // sign-agnostic, so treating it as signed is safe).
  always_comb begin
    sign1 = (mulsel != MULSEL_MULHU) && rs1_data[XLEN-1];
    sign2 = ((mulsel == MULSEL_MUL) || (mulsel == MULSEL_MULH)) && rs2_data[XLEN-1];
    mag1  = sign1 ? -rs1_data : rs1_data;
    mag2  = sign2 ? -rs2_data : rs2_data;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_mul_op(mulsel) && !flush) begin
          accept = 1'b1;
          stall  = 1'b1;
`ifdef MUL_ZERO_SKIP_EN
          next_state = zero_op ? DONE : RUN;
`else
          next_state = RUN;
`endif
        end
      end
      RUN: begin
        stall = 1'b1;
        if (last) next_state = FIX;
      end
      FIX: begin
        stall      = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state  <= IDLE;
      low_q  <= 1'b0;
      neg_q  <= 1'b0;
      rd_q   <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        low_q <= (mulsel == MULSEL_MUL);
        neg_q <= sign1 ^ sign2;
        rd_q  <= rd_in;
      end
      if ((state == FIX) && !flush) begin
        result <= low_q ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        rd_out <= rd_q;
      end
`ifdef MUL_ZERO_SKIP_EN
      if (accept && zero_op) begin
        result <= '0;
        rd_out <= rd_in;
      end
`endif
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !flush;

  mul_shift_add_core #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk     (clk),
    .rst     (Rst),
    .load    (accept),
    .step    (state == RUN),
    .negate  ((state == FIX) && neg_q),
    .mcand   (mag1),
    .mplier  (mag2),
    .last    (last),
    .product (product)
  );

endmodule

// File: tb/tb_mul_controller.sv
// Directed and randomized bench for mul_controller against a wide-arithmetic model.
module tb_mul_controller;
  import mul_pkg::*;

  localparam int XLEN  = 32;
  localparam int NITER = 32;

  logic            clk = 1'b0;
  logic            Rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      mulsel = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [4:0]      rd_in = '0;
  logic            flush = 1'b0;
  logic            stall, done, busy;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  int passed = 0;
  int total  = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;
  int cyc = 0;

  mul_controller #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .Rst(Rst), .start(start), .mulsel(mulsel),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
    .stall(stall), .done(done), .result(result), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Reference: extend each operand to 65 bits per its signedness, multiply exactly.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [64:0]  ea, eb;
    logic signed [129:0] p;
    ea = (op == MULSEL_MULH || op == MULSEL_MULHSU) ? {{33{a[31]}}, a} : {33'b0, a};
    eb = (op == MULSEL_MULH) ? {{33{b[31]}}, b} : {33'b0, b};
    p  = ea * eb;
    return (op == MULSEL_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_SKIP_EN
    return (a == 0 || b == 0) ? 1 : NITER + 2;
`else
    return NITER + 2;
`endif
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int lat, nst, el;
    bit got;
    logic [31:0] exp_r;
    exp_r = model(op, a, b);
    el = exp_latency(a, b);
    @(posedge clk); #1;
    start = 1'b1; mulsel = op; rs1_data = a; rs2_data = b; rd_in = rd;
    @(negedge clk);
    chk("stall_on_accept", stall, 1);
    nst = 1;
    @(posedge clk); #1;
    start = 1'b0; mulsel = MULSEL_NONE;
    rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    got = 0; lat = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1; lat = k;
        chk("stall_low_at_done", stall, 0);
        chk("result", result, exp_r);
        chk("rd_out", rd_out, rd);
      end else if (stall) nst++;
    end
    chk("latency", lat, el);
    chk("stall_cycles", nst, el);
    @(negedge clk);
    chk("done_one_pulse", done, 0);
    chk("idle_after_done", busy, 0);
    chk("result_held", result, exp_r);
    last_res = exp_r;
    last_rd  = rd;
  endtask

  initial begin
    int c1, c2;
    logic [31:0] r1, r2;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit saw;

    // Reset state
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_out", rd_out, 0);

    // Directed test plan cases
    run_op(MULSEL_MUL, 32'd7, 32'd6, 5'd5);
    chk("mul_7x6", result, 32'd42);
    run_op(MULSEL_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    chk("mulh_m1_m1", result, 32'h0000_0000);
    run_op(MULSEL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    chk("mulhu_ff_ff", result, 32'hFFFF_FFFE);
    run_op(MULSEL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    chk("mulhsu_m1_ff", result, 32'hFFFF_FFFF);
    run_op(MULSEL_MUL, 32'h8000_0000, 32'd2, 5'd4);
    chk("mul_min_x2", result, 32'h0000_0000);
    run_op(MULSEL_MULH, 32'h8000_0000, 32'd2, 5'd6);
    chk("mulh_min_x2", result, 32'hFFFF_FFFF);
    run_op(MULSEL_MUL, 32'd0, 32'd12345, 5'd7);
    chk("mul_zero", result, 32'd0);

    // Flush at T+10 aborts without writeback
    @(posedge clk); #1;
    start = 1'b1; mulsel = MULSEL_MULHU; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_in = 5'd9;
    saw = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0; mulsel = MULSEL_NONE;
      if (k == 10) flush = 1'b1;
      @(negedge clk);
      if (done) saw = 1;
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_no_done", saw | done, 0);
    chk("flush_idle", busy, 0);
    chk("flush_stall", stall, 0);
    chk("flush_result_kept", result, last_res);
    chk("flush_rd_kept", rd_out, last_rd);
    run_op(MULSEL_MULH, 32'hDEAD_BEEF, 32'h0000_0101, 5'd10);

    // Reset at T+20 mid-operation
    @(posedge clk); #1;
    start = 1'b1; mulsel = MULSEL_MUL; rs1_data = 32'd99; rs2_data = 32'd77; rd_in = 5'd11;
    @(posedge clk); #1 start = 1'b0; mulsel = MULSEL_NONE;
    repeat (18) @(posedge clk);
    #1 Rst = 1'b1;
    @(posedge clk); #1 Rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_result", result, 0);
    chk("midrst_rd_out", rd_out, 0);
    last_res = '0; last_rd = '0;

    // Back-to-back: start held high, second accept the cycle after done
    r1 = model(MULSEL_MUL, 32'd1000, 32'd3000);
    @(posedge clk); #1;
    start = 1'b1; mulsel = MULSEL_MUL; rs1_data = 32'd1000; rs2_data = 32'd3000; rd_in = 5'd12;
    c1 = -1; c2 = -1;
    for (int k = 0; k < 120 && c2 < 0; k++) begin
      @(negedge clk);
      if (done) begin
        if (c1 < 0) begin
          c1 = cyc;
          chk("b2b_first_result", result, r1);
          rs1_data = 32'hFFFF_FFF0; rs2_data = 32'd5; rd_in = 5'd13;
        end else begin
          c2 = cyc;
          start = 1'b0; mulsel = MULSEL_NONE;
          r2 = model(MULSEL_MUL, 32'hFFFF_FFF0, 32'd5);
          chk("b2b_second_result", result, r2);
          chk("b2b_second_rd", rd_out, 5'd13);
        end
      end
    end
    start = 1'b0; mulsel = MULSEL_NONE;
    chk("b2b_spacing", c2 - c1, NITER + 3);
    @(negedge clk);
    chk("b2b_idle", busy, 0);
    last_res = r2; last_rd = 5'd13;

    // Illegal / none mulsel with start: never accepted
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      start = 1'b1; mulsel = (s == 3) ? 3'b000 : 3'(5 + s);
      rs1_data = 32'd3; rs2_data = 32'd4;
      saw = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (stall || busy || done) saw = 1;
        @(posedge clk); #1;
      end
      chk("illegal_ignored", saw, 0);
      start = 1'b0; mulsel = MULSEL_NONE;
    end
    @(negedge clk);
    chk("illegal_result_kept", result, last_res);

    // Randomized operations against the model
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(1, 4));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h8000_0000;
        1:       rb = 32'h7FFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 5'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_controller.md
Name: mul_controller

Overview:
- Multi-cycle sequencer for the RV32M multiply group decoded as mulsel (001 mul, 010 mulh, 011 mulhsu, 100 mulhu).
- Sits in EX. Accepts one multiply, stalls the pipeline while an iterative shift-add engine runs, then returns a registered 32-bit result with its destination register.
- Flush or reset aborts cleanly with no writeback.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle. Legal values 1, 2, 4; must divide XLEN.
- NITER, XLEN/BITS_PER_CYCLE, RUN cycle count (derived localparam, not overridable).

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- start  in  1  multiply instruction valid in EX this cycle
- mulsel  in  3  operation select from decode; 000 = none
- rs1_data  in  XLEN  multiplicand (forwarded)
- rs2_data  in  XLEN  multiplier (forwarded)
- rd_in  in  5  destination register of the instruction
- flush  in  1  pipeline flush; aborts any operation
- stall  out  1  hold IF/ID/EX; combinational
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  product slice; held until next done
- rd_out  out  5  destination for result; valid with done
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; reset Rst is synchronous, active-high.
- Reset values: state=IDLE; done=0; busy=0; result=0; rd_out=0; all internal registers 0. Rst has priority over everything, including mid-operation.
- States:
  - IDLE: accept when start && mulsel in {001..100} && !flush; latch rd, op, operand signs and magnitudes; go to RUN.
  - RUN: one step per cycle; counter counts 0..NITER-1; go to FIX at the last step.
  - FIX: conditional two's-complement negate of the 64-bit product; select low half (mul) or high half (others) into result; go to DONE.
  - DONE: done=1; return to IDLE.
- Signedness: rs1 is signed for mulh and mulhsu. rs2 is signed for mulh only. mul uses magnitudes with sign fixup; its low 32 bits equal the unsigned low product. Negate when sign(rs1) XOR sign(rs2) over the signed operands.
- mulsel 101..111 is ignored (no accept, no stall); decode flags it illegal.
- Latency, with accept at cycle T: stall=1 in T..T+NITER+1; done=1 and stall=0 at T+NITER+2 (T+34 for defaults).
- stall is combinational: high in IDLE on the accepting cycle, high in RUN and FIX, low in DONE.
- start in DONE, RUN or FIX is ignored. The instruction that launched the operation is still in EX during DONE and must not be re-accepted.
- Back-to-back multiplies: the second is accepted in the IDLE cycle after DONE.
- flush in any state: next state IDLE, no done, result and rd_out unchanged. flush on the accept cycle prevents the accept.
- Counter wraps only through the state change; it is never compared past NITER-1.

Optional Feature:
- MUL_ZERO_SKIP_EN defined: on accept, if rs1_data==0 or rs2_data==0, go directly to DONE with result=0. done rises at T+1; stall is high only in T.
- Undefined: zero operands take the full latency and give the same result.

Decomposition:
- mul_pkg holds:
  - typedef enum logic [2:0] mul_state_t {IDLE, RUN, FIX, DONE};
  - localparams MULSEL_NONE, MULSEL_MUL, MULSEL_MULH, MULSEL_MULHSU, MULSEL_MULHU;
  - function is_mul_op(mulsel).
- Sub-module mul_shift_add_core: accumulator, multiplier shift register and step counter, controlled by load/step/negate strobes from the FSM in mul_controller.

Test Plan:
- mul 7 x 6, rd=5 -> stall held 34 cycles; done at T+34; result=42; rd_out=5.
- mulh 0xFFFFFFFF x 0xFFFFFFFF (-1 x -1) -> result=0x00000000. mulhu same operands -> result=0xFFFFFFFE. mulhsu -1 x 0xFFFFFFFF -> result=0xFFFFFFFF.
- mul 0x80000000 x 2 -> result=0x00000000. mulh same operands -> result=0xFFFFFFFF.
- flush asserted at T+10 -> IDLE at T+11; no done; result keeps previous value; a new start at T+12 completes normally.
- Rst at T+20 -> all outputs at reset values next cycle. Two back-to-back muls -> second accepted the cycle after first done; two done pulses exactly 35 cycles apart.
- MUL_ZERO_SKIP_EN: mul 0 x 12345 -> done at T+1 with result 0. Without the macro -> done at T+34 with result 0. mulsel=101 with start -> no stall, no done.
